// File: rtl/rt_mem_ctrl.sv
// Racetrack sequencing controller in front of mem_datapath: one core request at a time.
// Latency: rvalid 2+4n cycles after grant for writes, 2+4n+k for reads (n = addr[1:0], k = WAIT cycles).
// Backpressure: data_gnt_o is low unless idle; the core holds req/addr stable until granted.
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   data_req_i/addr/we/be/wdata       core address phase; data_gnt_o accepts it
//   lim_funct_i, range_i              LiM function (0 = plain access) and range flag
//   data_rvalid_o/rdata/err           one-cycle response phase
//   en_ab_o, be_b_o, addr_o           transaction enable and latched request to datapath
//   clk_m_o, Bz_s_o                   magnetic shift clock and direction (1 = forward)
//   write_pulse_o, read_pulse_o       one-cycle access strobes
//   write_data_o, write_en_data_o     latched write data and data-write enable
//   mask_o, lim_funct_o               latched LiM mask and function
//   range_active_o                    latched range flag, qualified by en_ab_o
//   r_data_i, r_valid_i               datapath read return
module rt_mem_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [2:0]            lim_funct_i,
  input  logic                  range_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  en_ab_o,
  output logic [3:0]            be_b_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  clk_m_o,
  output logic                  Bz_s_o,
  output logic                  write_pulse_o,
  output logic                  read_pulse_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_data_o,
  output logic [DATA_WIDTH-1:0] mask_o,
  output logic [2:0]            lim_funct_o,
  output logic                  range_active_o,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  input  logic                  r_valid_i
);

  localparam int WCNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, SHIFT_HI, SHIFT_LO, ACCESS, WAIT, UNSHIFT_HI, UNSHIFT_LO, RESP
  } state_t;

  state_t                state, next_state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  n_q;
  logic                  we_q;
  logic                  range_q;
  logic [WCNT_WIDTH-1:0] wait_cnt;

  logic accept;
  logic we_nx;
  logic range_nx;
  logic wait_timeout;
  logic [CNT_WIDTH-1:0] n_nx;

  assign data_gnt_o   = data_req_i && (state == IDLE) && !rst_i;
  assign accept       = data_gnt_o;
  assign n_nx         = data_addr_i[CNT_WIDTH-1:0];
  // On the accept edge the latches are not yet loaded, so look at the request directly.
  assign we_nx        = accept ? data_we_i : we_q;
  assign range_nx     = accept ? range_i : range_q;
  assign wait_timeout = (wait_cnt == WCNT_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (accept) next_state = (n_nx != '0) ? SHIFT_HI : ACCESS;
      SHIFT_HI:   next_state = SHIFT_LO;
      // Extra bit so the cnt+1 compare cannot wrap.
      SHIFT_LO:   next_state = (({1'b0, cnt} + 1'b1) < {1'b0, n_q}) ? SHIFT_HI : ACCESS;
      ACCESS:     if (we_q) next_state = (n_q != '0) ? UNSHIFT_HI : RESP;
                  else      next_state = WAIT;
      // A valid in the last allowed cycle still wins over the timeout.
      WAIT:       if (r_valid_i || wait_timeout)
                    next_state = (n_q != '0) ? UNSHIFT_HI : RESP;
      UNSHIFT_HI: next_state = UNSHIFT_LO;
      UNSHIFT_LO: next_state = (cnt == CNT_WIDTH'(1)) ? RESP : UNSHIFT_HI;
      RESP:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Strobes are decoded from next_state so they are registered yet line up with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_rvalid_o   <= 1'b0;
      data_rdata_o    <= '0;
      data_err_o      <= 1'b0;
      en_ab_o         <= 1'b0;
      be_b_o          <= '0;
      addr_o          <= '0;
      clk_m_o         <= 1'b0;
      Bz_s_o          <= 1'b0;
      write_pulse_o   <= 1'b0;
      read_pulse_o    <= 1'b0;
      write_data_o    <= '0;
      write_en_data_o <= 1'b0;
      mask_o          <= '0;
      lim_funct_o     <= '0;
      range_active_o  <= 1'b0;
      cnt             <= '0;
      n_q             <= '0;
      we_q            <= 1'b0;
      range_q         <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      en_ab_o        <= (next_state != IDLE);
      clk_m_o        <= (next_state == SHIFT_HI) || (next_state == UNSHIFT_HI);
      Bz_s_o         <= (next_state == SHIFT_HI) || (next_state == SHIFT_LO);
      write_pulse_o  <= (next_state == ACCESS) && we_nx;
      read_pulse_o   <= (next_state == ACCESS) && !we_nx;
      data_rvalid_o  <= (next_state == RESP);
      range_active_o <= (next_state != IDLE) && range_nx;

      case (state)
        IDLE: begin
          if (accept) begin
            addr_o          <= data_addr_i;
            be_b_o          <= data_be_i;
            write_data_o    <= data_wdata_i;
            lim_funct_o     <= lim_funct_i;
            // A non-zero function turns the write into a LiM mask store.
            write_en_data_o <= (lim_funct_i == 3'b000);
            mask_o          <= (lim_funct_i != 3'b000) ? data_wdata_i : '0;
            we_q            <= data_we_i;
            range_q         <= range_i;
            n_q             <= n_nx;
            cnt             <= '0;
            wait_cnt        <= '0;
            data_rdata_o    <= '0;
            data_err_o      <= 1'b0;
          end
        end
        SHIFT_LO:   cnt <= cnt + 1'b1;
        UNSHIFT_LO: cnt <= cnt - 1'b1;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (r_valid_i) begin
            data_rdata_o <= r_data_i;
          end else if (wait_timeout) begin
            data_err_o   <= 1'b1;
            data_rdata_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rt_mem_ctrl.sv
module tb_rt_mem_ctrl;
  localparam int TO = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic [7:0]  data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic [2:0]  lim_funct_i;
  logic        range_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o, en_ab_o;
  logic [31:0] data_rdata_o, write_data_o, mask_o, r_data_i;
  logic [3:0]  be_b_o;
  logic [7:0]  addr_o;
  logic        clk_m_o, Bz_s_o, write_pulse_o, read_pulse_o, write_en_data_o, range_active_o;
  logic [2:0]  lim_funct_o;
  logic        r_valid_i;

  rt_mem_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(2), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_req_i(data_req_i), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .lim_funct_i(lim_funct_i), .range_i(range_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .en_ab_o(en_ab_o), .be_b_o(be_b_o), .addr_o(addr_o), .clk_m_o(clk_m_o), .Bz_s_o(Bz_s_o),
    .write_pulse_o(write_pulse_o), .read_pulse_o(read_pulse_o), .write_data_o(write_data_o),
    .write_en_data_o(write_en_data_o), .mask_o(mask_o), .lim_funct_o(lim_funct_o),
    .range_active_o(range_active_o), .r_data_i(r_data_i), .r_valid_i(r_valid_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          rcyc;   // expected rvalid cycle
    int          acc;    // expected access-strobe cycle
    int          n;
    int          d;      // datapath return delay after read strobe, 0 = never
    logic        we;
    logic        err;
    logic        rng;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  funct;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [256];
  int          last_r = -1;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, en_ab_o, be_b_o, addr_o,
            clk_m_o, Bz_s_o, write_pulse_o, read_pulse_o, write_data_o, write_en_data_o,
            mask_o, lim_funct_o, range_active_o};
  endfunction

  // Monitor: pulse bookkeeping and scoreboard pop on every response.
  int   fwd, back, wp, rp;
  logic acc_seen, order_bad, clkm_prev;
  exp_t m;
  always @(negedge clk_i) begin
    if (rst_i) begin
      fwd = 0; back = 0; wp = 0; rp = 0;
      acc_seen = 0; order_bad = 0; clkm_prev = 0;
    end else begin
      if (clk_m_o) begin
        chk("clk_m_consecutive", clkm_prev, 0);
        if (Bz_s_o) begin fwd++;  if (acc_seen)  order_bad = 1; end
        else        begin back++; if (!acc_seen) order_bad = 1; end
      end
      clkm_prev = clk_m_o;
      if (write_pulse_o || read_pulse_o) begin
        acc_seen = 1;
        if (write_pulse_o) wp++;
        if (read_pulse_o)  rp++;
        if (q.size() == 0) chk("strobe_unexpected", 1, 0);
        else begin
          m = q[0];
          chk("access_cycle", cyc, m.acc);
          if (write_pulse_o) begin
            chk("wr_addr", addr_o, m.addr);
            chk("wr_be", be_b_o, m.be);
            chk("wr_data", write_data_o, m.wdata);
            chk("wr_en_data", write_en_data_o, m.funct == 3'b000);
            chk("wr_mask", mask_o, (m.funct != 3'b000) ? m.wdata : 32'h0);
            chk("wr_lim_funct", lim_funct_o, m.funct);
          end
        end
      end
      if (data_rvalid_o) begin
        if (q.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          m = q.pop_front();
          chk("rvalid_cycle", cyc, m.rcyc);
          chk("resp_err", data_err_o, m.err);
          if (!m.we) chk("resp_rdata", data_rdata_o, m.rdata);
          chk("fwd_pulses", fwd, m.n);
          chk("back_pulses", back, m.n);
          chk("write_pulses", wp, m.we);
          chk("read_pulses", rp, !m.we);
          chk("shift_order", order_bad, 0);
          chk("en_ab_resp", en_ab_o, 1);
          chk("range_active", range_active_o, m.rng);
        end
        fwd = 0; back = 0; wp = 0; rp = 0; acc_seen = 0; order_bad = 0;
      end
    end
  end

  // Datapath model: junk valid during the access cycle, real data d cycles after the strobe.
  int rd_d;
  initial begin
    r_valid_i = 1'b0;
    r_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i && read_pulse_o && q.size() != 0) begin
        rd_d      = q[0].d;
        r_valid_i = 1'b1;
        r_data_i  = $urandom;
        @(posedge clk_i); #1;
        r_valid_i = 1'b0;
        if (rd_d > 0) begin
          if (rd_d > 1) begin repeat (rd_d - 1) @(posedge clk_i); #1; end
          r_valid_i = 1'b1;
          r_data_i  = mem[addr_o];
          @(posedge clk_i); #1;
          r_valid_i = 1'b0;
        end
      end
    end
  end

  // Present a request, check gnt each cycle against the model, push the expected response.
  task automatic issue(input logic [7:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input logic [2:0] f, input logic rg, input int d);
    exp_t e;
    int   w;
    int   k;
    data_req_i = 1'b1; data_addr_i = a; data_we_i = we; data_be_i = be;
    data_wdata_i = wd; lim_funct_i = f; range_i = rg;
    #1;
    w = 0;
    while (1) begin
      chk("gnt", data_gnt_o, cyc > last_r);
      if (data_gnt_o) break;
      if (w >= 100) begin
        chk("gnt_timeout", 0, 1);
        data_req_i = 1'b0;
        return;
      end
      @(negedge clk_i); #2;
      w++;
    end
    e.n = int'(a[1:0]); e.d = d; e.we = we; e.rng = rg; e.addr = a; e.be = be;
    e.wdata = wd; e.funct = f;
    e.acc = cyc + 1 + 2 * e.n;
    e.err = 1'b0; e.rdata = '0; k = 0;
    if (!we) begin
      if (d >= 1 && d <= TO) begin k = d; e.rdata = mem[a]; end
      else begin k = TO; e.err = 1'b1; end
    end
    e.rcyc = cyc + 2 + 4 * e.n + k;
    if (we && f == 3'b000) mem[a] = wd;
    q.push_back(e);
    last_r = e.rcyc;
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 300) begin @(negedge clk_i); w++; end
    if (q.size() != 0) begin chk("drain_timeout", q.size(), 0); q.delete(); end
    @(negedge clk_i); #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_i = 1'b1; data_req_i = 0; data_addr_i = 0; data_we_i = 0; data_be_i = 0;
    data_wdata_i = 0; lim_funct_i = 0; range_i = 0;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i); #2;

    issue(8'h04, 1, 4'hF, 32'hDEADBEEF, 3'b000, 0, 0); data_req_i = 0; drain();
    issue(8'h07, 0, 4'hF, 32'h0, 3'b000, 1, 2);          data_req_i = 0; drain();
    issue(8'h12, 1, 4'h3, 32'h0000FFFF, 3'b010, 1, 0);   data_req_i = 0; drain();
    // Back-to-back with req held high throughout.
    issue(8'h05, 1, 4'hF, 32'h12345678, 3'b000, 0, 0);
    issue(8'h05, 0, 4'hF, 32'h0, 3'b000, 0, 1);
    issue(8'h0B, 1, 4'hC, 32'hA5A5A5A5, 3'b000, 1, 0);   data_req_i = 0; drain();
    issue(8'h20, 0, 4'hF, 32'h0, 3'b000, 0, 0);          data_req_i = 0; drain();
    issue(8'h21, 0, 4'hF, 32'h0, 3'b000, 0, TO);         data_req_i = 0; drain();

    // Reset during the first SHIFT_LO of an n=3 write.
    issue(8'h03, 1, 4'hF, 32'hCAFEF00D, 3'b000, 0, 0);
    data_req_i = 0;
    mem[8'h03] = 32'hCAFEF00D;
    @(posedge clk_i); #1;
    chk("pre_rst_shift_lo", {en_ab_o, clk_m_o, Bz_s_o}, 3'b101);
    rst_i = 1'b1; data_req_i = 1'b1;
    @(negedge clk_i);
    chk("mid_op_reset_outputs", all_outs(), 0);
    data_req_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    q.delete();
    last_r = cyc;
    repeat (25) @(negedge clk_i);
    #2;
    issue(8'h03, 0, 4'hF, 32'h0, 3'b000, 0, 3);          data_req_i = 0; drain();

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [2:0] f;
      int         gap;
      a   = 8'($urandom);
      f   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      issue(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, f,
            1'($urandom_range(0, 1)), $urandom_range(0, TO + 2));
      if ($urandom_range(0, 2) != 0) begin
        data_req_i = 1'b0;
        gap = $urandom_range(0, 3);
        if (gap > 0) begin repeat (gap) @(negedge clk_i); #2; end
      end
    end
    data_req_i = 1'b0;
    drain();
    repeat (5) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
